// File: rtl/lm32_wb_bridge.sv
// Purpose: registered bridge from an LM32 byte-addressed Wishbone port to the ProNoC word-addressed classic bus.
// Latency: request sampled in cycle 0, m_stb_o in cycle 1; a slave response in cycle k gives s_ack_o/s_err_o in cycle k+1.
// Backpressure: one beat in flight; the CPU is held off until the response pulse, and en_i low blocks new requests.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 gates acceptance of new requests only
//   s_*                  CPU-side Wishbone slave (byte address, bursts split into single beats)
//   m_*                  bus-side classic Wishbone master (word address, cti/bte always 0)
//   timeout_o            one-cycle pulse, coincident with s_err_o, when the watchdog aborts a cycle
module lm32_wb_bridge #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SELW      = DW / 8,
  parameter int ASHIFT    = $clog2(SELW),
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [AW-1:0]   s_adr_i,
  input  logic [DW-1:0]   s_dat_i,
  input  logic [SELW-1:0] s_sel_i,
  input  logic            s_we_i,
  input  logic            s_cyc_i,
  input  logic            s_stb_i,
  input  logic [2:0]      s_cti_i,
  input  logic [1:0]      s_bte_i,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic            s_err_o,
  output logic            s_rty_o,
  output logic [AW-1:0]   m_adr_o,
  output logic [DW-1:0]   m_dat_o,
  output logic [SELW-1:0] m_sel_o,
  output logic            m_we_o,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic [2:0]      m_cti_o,
  output logic [1:0]      m_bte_o,
  input  logic [DW-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i,
  output logic            timeout_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  localparam logic [RW-1:0] RTY_LOAD = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   rty_q, rty_d;
  logic            ack_d, err_d, to_d;
  logic            cap_req, cap_rdat;

  // Burst type/cycle type carry no information for single-beat conversion.
  logic unused_in;
  assign unused_in = ^{s_cti_i, s_bte_i};

  assign s_rty_o = 1'b0;
  assign m_cti_o = 3'b000;
  assign m_bte_o = 2'b00;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    rty_d    = rty_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    cap_req  = 1'b0;
    cap_rdat = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = TMO_LOAD;
        rty_d = RTY_LOAD;
        if (s_cyc_i && s_stb_i && en_i) begin
          cap_req = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d = tmo_q - TW'(1);
        // Any slave response, including RTY, beats the watchdog on the last cycle.
        if (m_err_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (m_ack_i) begin
          ack_d    = 1'b1;
          cap_rdat = !m_we_o;
          state_d  = RESP;
        end else if (m_rty_i) begin
          if (rty_q != '0) begin
            rty_d   = rty_q - RW'(1);
            state_d = GAP;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end else if (tmo_q == TW'(1)) begin
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      GAP: begin
        tmo_d   = TMO_LOAD;
        state_d = REQ;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      rty_q     <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      s_ack_o   <= 1'b0;
      s_err_o   <= 1'b0;
      timeout_o <= 1'b0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel_o   <= '0;
      m_we_o    <= 1'b0;
      s_dat_o   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      rty_q     <= rty_d;
      m_cyc_o   <= (state_d == REQ);
      m_stb_o   <= (state_d == REQ);
      s_ack_o   <= ack_d;
      s_err_o   <= err_d;
      timeout_o <= to_d;
      if (cap_req) begin
        m_adr_o <= s_adr_i >> ASHIFT;
        m_dat_o <= s_dat_i;
        m_sel_o <= s_sel_i;
        m_we_o  <= s_we_i;
      end
      if (cap_rdat) begin
        s_dat_o <= m_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_lm32_wb_bridge.sv
module tb_lm32_wb_bridge;

  localparam int TO = 4;
  localparam int MR = 3;
  localparam int R_NONE = 0, R_ACK = 1, R_ERR = 2, R_RTY = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [31:0] s_adr, s_dat, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack_o, s_err_o, s_rty_o;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack, m_err, m_rty, timeout_o;
  logic [2:0]  m_cti_o;
  logic [1:0]  m_bte_o;

  logic [31:0] s64_adr, m64_adr_o;
  logic [63:0] s64_dat, s64_dat_o, m64_dat_o, m64_dat_i;
  logic [7:0]  s64_sel, m64_sel_o;
  logic        s64_we, s64_cyc, s64_stb, s64_ack_o, s64_err_o, s64_rty_o;
  logic        m64_we_o, m64_cyc_o, m64_stb_o, m64_ack, m64_err, m64_rty, m64_to_o;
  logic [2:0]  m64_cti_o;
  logic [1:0]  m64_bte_o;

  int errs = 0;
  int checks = 0;
  int sc_wait[8];
  int sc_resp[8];
  int sc_n;
  logic [31:0] last_rd;
  logic [31:0] force_rd;
  bit          use_force;

  lm32_wb_bridge #(.DW(32), .AW(32), .TIMEOUT(TO), .MAX_RETRY(MR)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_sel_i(s_sel), .s_we_i(s_we),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_cti_i(s_cti), .s_bte_i(s_bte),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack), .m_err_i(m_err), .m_rty_i(m_rty),
    .timeout_o(timeout_o)
  );

  lm32_wb_bridge #(.DW(64), .AW(32), .TIMEOUT(8), .MAX_RETRY(MR)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .s_adr_i(s64_adr), .s_dat_i(s64_dat), .s_sel_i(s64_sel), .s_we_i(s64_we),
    .s_cyc_i(s64_cyc), .s_stb_i(s64_stb), .s_cti_i(3'b000), .s_bte_i(2'b00),
    .s_dat_o(s64_dat_o), .s_ack_o(s64_ack_o), .s_err_o(s64_err_o), .s_rty_o(s64_rty_o),
    .m_adr_o(m64_adr_o), .m_dat_o(m64_dat_o), .m_sel_o(m64_sel_o), .m_we_o(m64_we_o),
    .m_cyc_o(m64_cyc_o), .m_stb_o(m64_stb_o), .m_cti_o(m64_cti_o), .m_bte_o(m64_bte_o),
    .m_dat_i(m64_dat_i), .m_ack_i(m64_ack), .m_err_i(m64_err), .m_rty_i(m64_rty),
    .timeout_o(m64_to_o)
  );

  // One CPU beat against the scripted slave. The expected outcome is derived
  // from the response script alone: attempts, bus cycles, latency, result.
  task automatic do_beat(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                         input logic we, input logic [2:0] cti, input bit drop_cyc,
                         input bit drop_en, input bit hold_cyc);
    int exp_out, exp_att, exp_stb, exp_lat, exp_to, retries;
    int att, wcnt, stb_tot, gap;
    bit done, prev_stb;
    logic [31:0] ack_dat;
    begin
      retries = 0; exp_stb = 0; exp_lat = 0; exp_to = 0; exp_out = R_ERR; exp_att = 0;
      for (int a = 0; a < 16; a++) begin
        int r, w;
        r = (a < sc_n) ? sc_resp[a] : R_NONE;
        w = (a < sc_n) ? sc_wait[a] : 0;
        exp_att = a + 1;
        if (r == R_NONE || w + 1 > TO) begin
          exp_stb += TO; exp_to = 1; exp_out = R_ERR; break;
        end
        exp_stb += w + 1;
        if (r == R_ACK) begin exp_out = R_ACK; break; end
        if (r == R_ERR) begin exp_out = R_ERR; break; end
        if (retries < MR) begin retries++; exp_lat++; end
        else begin exp_out = R_ERR; break; end
      end
      exp_lat += exp_stb + 1;

      s_adr = adr; s_dat = wdat; s_sel = sel; s_we = we; s_cti = cti; s_bte = 2'($urandom);
      s_cyc = 1'b1; s_stb = 1'b1;
      prev_stb = 1'b0; att = 0; wcnt = 0; stb_tot = 0; gap = 0; done = 1'b0; ack_dat = '0;
      for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
        @(posedge clk); @(negedge clk);
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
        m_dat_i = use_force ? force_rd : $urandom;
        if (cyc == 1) begin
          if (drop_cyc) begin s_cyc = 1'b0; s_stb = 1'b0; end
          if (drop_en) en = 1'b0;
        end
        if (s_ack_o || s_err_o || timeout_o) begin
          done = 1'b1;
          checks++; if (s_ack_o !== (exp_out == R_ACK)) begin errs++; $display("FAIL beat_ack adr=%h got=%b want=%b", adr, s_ack_o, exp_out == R_ACK); end
          checks++; if (s_err_o !== (exp_out == R_ERR)) begin errs++; $display("FAIL beat_err adr=%h got=%b want=%b", adr, s_err_o, exp_out == R_ERR); end
          checks++; if (timeout_o !== (exp_to == 1)) begin errs++; $display("FAIL beat_timeout_pulse adr=%h got=%b want=%0d", adr, timeout_o, exp_to); end
          checks++; if (cyc != exp_lat) begin errs++; $display("FAIL beat_latency adr=%h got=%0d want=%0d", adr, cyc, exp_lat); end
          checks++; if (att != exp_att) begin errs++; $display("FAIL beat_attempts adr=%h got=%0d want=%0d", adr, att, exp_att); end
          checks++; if (stb_tot != exp_stb) begin errs++; $display("FAIL beat_stb_cycles adr=%h got=%0d want=%0d", adr, stb_tot, exp_stb); end
          checks++; if (m_cyc_o !== 1'b0) begin errs++; $display("FAIL beat_cyc_in_resp got=%b want=0", m_cyc_o); end
          if (exp_out == R_ACK && !we) last_rd = ack_dat;
          checks++; if (s_dat_o !== last_rd) begin errs++; $display("FAIL beat_rdata adr=%h got=%h want=%h", adr, s_dat_o, last_rd); end
          if (!hold_cyc) s_cyc = 1'b0;
          s_stb = 1'b0;
        end else if (m_stb_o) begin
          if (!prev_stb) begin
            att++; wcnt = 0;
            checks++; if (m_adr_o !== adr / 4) begin errs++; $display("FAIL req_adr got=%h want=%h", m_adr_o, adr / 4); end
            checks++; if ({m_we_o, m_sel_o, m_cti_o, m_bte_o} !== {we, sel, 3'b000, 2'b00}) begin
              errs++; $display("FAIL req_ctl we/sel/cti/bte got=%b/%h/%b/%b want=%b/%h/000/00", m_we_o, m_sel_o, m_cti_o, m_bte_o, we, sel);
            end
            if (we) begin
              checks++; if (m_dat_o !== wdat) begin errs++; $display("FAIL req_wdat got=%h want=%h", m_dat_o, wdat); end
            end
            if (att > 1) begin
              checks++; if (gap != 1) begin errs++; $display("FAIL retry_gap got=%0d want=1", gap); end
            end
          end
          stb_tot++;
          if (att <= sc_n && wcnt == sc_wait[att-1]) begin
            case (sc_resp[att-1])
              R_ACK: begin m_ack = 1'b1; ack_dat = m_dat_i; end
              R_ERR: m_err = 1'b1;
              R_RTY: m_rty = 1'b1;
              default: ;
            endcase
          end
          wcnt++;
          gap = 0;
        end else begin
          gap++;
        end
        prev_stb = m_stb_o;
      end
      if (!done) begin errs++; checks++; $display("FAIL beat_hang adr=%h no response within 64 cycles", adr); end
      @(posedge clk); @(negedge clk);
      m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
      checks++; if ({s_ack_o, s_err_o, timeout_o} !== 3'b000) begin errs++; $display("FAIL resp_one_cycle got=%b want=000", {s_ack_o, s_err_o, timeout_o}); end
    end
  endtask

  task automatic script1(input int w, input int r);
    sc_n = 1; sc_wait[0] = w; sc_resp[0] = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1;
    s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0; s_cti = '0; s_bte = '0;
    m_dat_i = 32'hFFFF_FFFF; m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
    s64_adr = '0; s64_dat = '0; s64_sel = '0; s64_we = 1'b0; s64_cyc = 1'b0; s64_stb = 1'b0;
    m64_dat_i = '0; m64_ack = 1'b0; m64_err = 1'b0; m64_rty = 1'b0;
    use_force = 1'b0; force_rd = '0; last_rd = '0;
    repeat (2) @(negedge clk);
    checks++; if ({m_cyc_o, m_stb_o, s_ack_o, s_err_o, s_rty_o, timeout_o, m_we_o} !== 7'b0) begin
      errs++; $display("FAIL reset_ctl got=%b want=0000000", {m_cyc_o, m_stb_o, s_ack_o, s_err_o, s_rty_o, timeout_o, m_we_o});
    end
    checks++; if ({m_adr_o, m_dat_o, m_sel_o} !== 68'b0) begin errs++; $display("FAIL reset_req got=%h/%h/%h want=0", m_adr_o, m_dat_o, m_sel_o); end
    checks++; if (s_dat_o !== 32'h0) begin errs++; $display("FAIL reset_sdat got=%h want=0", s_dat_o); end
    checks++; if ({m_cti_o, m_bte_o} !== 5'b0) begin errs++; $display("FAIL reset_cti_bte got=%b want=0", {m_cti_o, m_bte_o}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read32;
    script1(0, R_ACK);
    use_force = 1'b1; force_rd = 32'hDEAD_BEEF;
    do_beat(32'h0000_1008, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    use_force = 1'b0;
    checks++; if (m_adr_o !== 32'h0000_0402) begin errs++; $display("FAIL read32_adr got=%h want=00000402", m_adr_o); end
    checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin errs++; $display("FAIL read32_data got=%h want=deadbeef", s_dat_o); end
    // A later write must leave the captured read data untouched.
    script1(1, R_ACK);
    do_beat(32'h0000_2000, 32'h1234_5678, 4'h3, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin errs++; $display("FAIL read_hold got=%h want=deadbeef", s_dat_o); end
  endtask

  task automatic test_write64;
    int acks;
    bit seen;
    acks = 0; seen = 1'b0;
    s64_adr = 32'h0000_0040; s64_dat = 64'h0123_4567_89AB_CDEF; s64_sel = 8'hFF; s64_we = 1'b1;
    s64_cyc = 1'b1; s64_stb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      m64_ack = 1'b0;
      if (s64_ack_o) begin acks++; s64_cyc = 1'b0; s64_stb = 1'b0; end
      if (m64_stb_o && !seen) begin
        seen = 1'b1;
        checks++; if (m64_adr_o !== 32'h0000_0008) begin errs++; $display("FAIL w64_adr got=%h want=00000008", m64_adr_o); end
        checks++; if ({m64_we_o, m64_sel_o} !== 9'h1FF) begin errs++; $display("FAIL w64_we_sel got=%b/%h want=1/ff", m64_we_o, m64_sel_o); end
        checks++; if (m64_dat_o !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL w64_dat got=%h want=0123456789abcdef", m64_dat_o); end
        m64_ack = 1'b1;
      end
    end
    checks++; if (acks != 1) begin errs++; $display("FAIL w64_ack_count got=%0d want=1", acks); end
  endtask

  task automatic test_retry;
    sc_n = 3;
    sc_wait[0] = 0; sc_resp[0] = R_RTY;
    sc_wait[1] = 1; sc_resp[1] = R_RTY;
    sc_wait[2] = 0; sc_resp[2] = R_ACK;
    do_beat(32'h0000_0300, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    sc_n = 4;
    for (int i = 0; i < 4; i++) begin sc_wait[i] = 0; sc_resp[i] = R_RTY; end
    do_beat(32'h0000_0304, 32'hA5A5_0000, 4'hC, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    script1(0, R_NONE);
    do_beat(32'h0000_0500, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    script1(TO - 1, R_ACK);   // ack on the final watchdog cycle wins
    do_beat(32'h0000_0504, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    script1(TO, R_ACK);       // ack one cycle too late
    do_beat(32'h0000_0508, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_burst;
    logic [2:0] cti;
    for (int i = 0; i < 4; i++) begin
      cti = (i == 3) ? 3'b111 : 3'b010;
      script1(i % 2, R_ACK);
      do_beat(32'h0000_0100 + 32'(4 * i), 32'h0, 4'hF, 1'b0, cti, 1'b0, 1'b0, i != 3);
      checks++; if (m_adr_o !== 32'h40 + 32'(i)) begin errs++; $display("FAIL burst_adr beat=%0d got=%h want=%h", i, m_adr_o, 32'h40 + 32'(i)); end
    end
  endtask

  task automatic test_enable;
    en = 1'b0; s_adr = 32'h0000_0700; s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (m_cyc_o !== 1'b0) begin errs++; $display("FAIL en_gate cyc=%0d got=%b want=0", c, m_cyc_o); end
    end
    en = 1'b1;
    script1(2, R_ACK);
    do_beat(32'h0000_0704, 32'h0, 4'hF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    s_cyc = 1'b1; s_stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (m_cyc_o !== 1'b0) begin errs++; $display("FAIL en_fall_gate cyc=%0d got=%b want=0", c, m_cyc_o); end
    end
    s_cyc = 1'b0; s_stb = 1'b0; en = 1'b1;
    @(negedge clk);
    // CPU abandons its cycle while the bus cycle is outstanding.
    script1(1, R_ACK);
    do_beat(32'h0000_0708, 32'h0, 4'hF, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    s_adr = 32'h0000_0800; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (m_cyc_o !== 1'b1) begin errs++; $display("FAIL rst_mid_pre got=%b want=1", m_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({m_cyc_o, m_stb_o} !== 2'b00) begin errs++; $display("FAIL rst_async_drop got=%b want=00", {m_cyc_o, m_stb_o}); end
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      m_ack = (c < 2);
      @(posedge clk); @(negedge clk);
      if (s_ack_o || m_cyc_o) bad++;
    end
    m_ack = 1'b0;
    checks++; if (bad != 0) begin errs++; $display("FAIL rst_no_ack got=%0d want=0 ack/cyc cycles", bad); end
    last_rd = '0;
  endtask

  task automatic test_random;
    int k, idle;
    logic [2:0] cti;
    for (int t = 0; t < 40; t++) begin
      sc_n = $urandom_range(1, 5);
      for (int i = 0; i < sc_n; i++) begin
        sc_wait[i] = $urandom_range(0, 4);
        sc_resp[i] = $urandom_range(0, 3);
      end
      k = $urandom_range(0, 2);
      cti = (k == 0) ? 3'b000 : (k == 1) ? 3'b010 : 3'b111;
      do_beat($urandom, $urandom, 4'($urandom), 1'($urandom), cti, 1'b0, 1'b0, 1'b0);
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_read32;
    test_write64;
    test_retry;
    test_timeout;
    test_burst;
    test_enable;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
